// File: rtl/seq_det_ctrl.sv
// Scans one WIDTH-bit word MSB first for a programmable 3-bit pattern and
// reports the number of (overlapping) matches plus a per-bit completion mask.
module seq_det_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_pattern,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic [WIDTH-1:0] out_mask,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [1:0]       hist_q, hist_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [2:0]       pat_q, pat_d;
  logic [2:0]       scan_pat_q, scan_pat_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             cur_bit;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    idx_d       = idx_q;
    hist_d      = hist_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    pat_d       = pat_q;
    scan_pat_d  = scan_pat_q;
    cur_bit     = sr_q[WIDTH-1];

    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          pat_d = cfg_pattern;
        end
        if (in_valid) begin
          // Snapshot the pattern so a same-edge config write affects only the next word
          sr_d       = in_data;
          idx_d      = CW'(WIDTH - 1);
          hist_d     = 2'b00;
          cnt_d      = '0;
          mask_d     = '0;
          scan_pat_d = pat_q;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        sr_d   = {sr_q[WIDTH-2:0], 1'b0};
        hist_d = {hist_q[0], cur_bit};
        if ((idx_q <= CW'(WIDTH - 3)) && ({hist_q, cur_bit} == scan_pat_q)) begin
          mask_d[idx_q] = 1'b1;
          cnt_d         = cnt_q + CW'(1);
        end
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == SHIFT) || (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      idx_q       <= '0;
      hist_q      <= 2'b00;
      cnt_q       <= '0;
      mask_q      <= '0;
      pat_q       <= 3'b101;
      scan_pat_q  <= 3'b101;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      idx_q       <= idx_d;
      hist_q      <= hist_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      pat_q       <= pat_d;
      scan_pat_q  <= scan_pat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_count = cnt_q;
  assign out_mask  = mask_q;

endmodule
